jelly_rtos_dispatcher: RTL and testbench
========================================

// Module: jelly_rtos_dispatcher
// PURPOSE
//  Consumes the head (top_id/top_pri/top_valid) of the ready-queue priority queue and tracks the running task.
//  When the queue head differs from the running task, issues one context-switch request to the CPU over a valid/ready handshake.
//  Sits directly downstream of jelly_priority_queue in the RTOS core.
//  Lower pri value = higher priority; tie order is resolved by the queue.
// PARAMETERS
//  ID_WIDTH     32  task id width (matches queue)
//  PRI_WIDTH     4  priority width (matches queue)
//  COUNT_WIDTH  16  width of completed-switch counter
// PORTS
//  clk         in   1            clock; all logic on posedge
//  reset       in   1            synchronous, active-high
//  cke         in   1            clock enable; 0 freezes all state, dsp_ready ignored
//  top_id      in   ID_WIDTH     queue head id
//  top_pri     in   PRI_WIDTH    queue head priority
//  top_valid   in   1            queue non-empty
//  dis_dsp     in   1            dispatch disable (lock)
//  dsp_id      out  ID_WIDTH     requested next task id (0 when dsp_idle)
//  dsp_pri     out  PRI_WIDTH    requested next priority (0 when dsp_idle)
//  dsp_idle    out  1            request is switch-to-idle (queue empty)
//  dsp_valid   out  1            switch request valid
//  dsp_ready   in   1            CPU accepts switch
//  run_id      out  ID_WIDTH     current running task id
//  run_pri     out  PRI_WIDTH    current running priority
//  run_valid   out  1            a task is running (0 = idle)
//  dsp_pend    out  1            switch needed but blocked by dis_dsp
//  switch_count out COUNT_WIDTH  completed handshakes, wraps modulo 2^COUNT_WIDTH
// BEHAVIOUR
//  Reset values: state=ST_IDLE, all outputs 0.
//  States:
//   ST_IDLE  run_valid=0
//   ST_RUN   run_valid=1
//   ST_REQ   dsp_valid=1
//  need (evaluated combinationally in ST_IDLE/ST_RUN):
//   (top_valid && (!run_valid || top_id!=run_id || top_pri!=run_pri)) || (!top_valid && run_valid).
//  ST_IDLE/ST_RUN, edge with cke && need && !dis_dsp:
//   latch dsp_id/dsp_pri = top (or 0 if !top_valid) and dsp_idle = !top_valid.
//   Go to ST_REQ; dsp_valid rises the cycle after the edge.
//  dsp_pend = need && dis_dsp, combinational, and only in ST_IDLE/ST_RUN. It is 0 in ST_REQ.
//  ST_REQ:
//   - dsp_* held stable until the handshake; no retargeting even if top_* changes.
//   - dis_dsp does not withdraw an outstanding request.
//  Handshake edge (cke && dsp_valid && dsp_ready):
//   - run_id/run_pri <= dsp_id/dsp_pri; run_valid <= !dsp_idle.
//   - dsp_valid <= 0; switch_count++.
//   - state <= dsp_idle ? ST_IDLE : ST_RUN.
//  need is re-evaluated the cycle after the handshake, so requests are separated by at least one idle cycle.
//  A pri change of the running task alone (same id) is a need. It produces a request with the same id.
//  Reset mid-request: dsp_valid drops the next cycle; no handshake is counted.
//  switch_count: all-ones + 1 -> 0.
// TESTING
//  1. Reset, top_valid=0 for 5 cycles.
//     -> dsp_valid=0, run_valid=0, dsp_pend=0, switch_count=0.
//  2. top={0x102,2,1}, dsp_ready=1.
//     -> dsp_valid 1 cycle with dsp_id=0x102, dsp_idle=0.
//     -> then run_id=0x102, run_pri=2, count=1.
//  3. Running 0x102; top becomes {0x100,0}; dsp_ready=0 for 3 cycles; top changes to 0x101 meanwhile.
//     -> dsp_id stays 0x100 until ready.
//     -> a second request for 0x101 follows after a 1-cycle gap.
//  4. dis_dsp=1, top becomes 0x105.
//     -> dsp_pend=1, dsp_valid=0.
//     -> releasing dis_dsp gives dsp_valid next cycle with dsp_id=0x105.
//  5. Running 0x105, top_valid falls to 0.
//     -> request with dsp_idle=1, dsp_id=0.
//     -> after handshake run_valid=0, state ST_IDLE.
//  6. cke=0 during ST_REQ with dsp_ready=1 -> no handshake, outputs frozen.
//     COUNT_WIDTH=2, 4 switches -> switch_count wraps to 0.
//     Reset asserted in ST_REQ -> all outputs 0.

Source files
------------

// File: rtl/jelly_rtos_dispatcher.sv
// RTOS dispatcher: follows the ready-queue head and issues one context-switch
// request to the CPU over valid/ready whenever the head differs from the running task.
module jelly_rtos_dispatcher #(
  parameter int unsigned ID_WIDTH    = 32,
  parameter int unsigned PRI_WIDTH   = 4,
  parameter int unsigned COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cke,
  input  logic [ID_WIDTH-1:0]    top_id,
  input  logic [PRI_WIDTH-1:0]   top_pri,
  input  logic                   top_valid,
  input  logic                   dis_dsp,
  output logic [ID_WIDTH-1:0]    dsp_id,
  output logic [PRI_WIDTH-1:0]   dsp_pri,
  output logic                   dsp_idle,
  output logic                   dsp_valid,
  input  logic                   dsp_ready,
  output logic [ID_WIDTH-1:0]    run_id,
  output logic [PRI_WIDTH-1:0]   run_pri,
  output logic                   run_valid,
  output logic                   dsp_pend,
  output logic [COUNT_WIDTH-1:0] switch_count
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_REQ  = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [ID_WIDTH-1:0]    dsp_id_q, dsp_id_d;
  logic [PRI_WIDTH-1:0]   dsp_pri_q, dsp_pri_d;
  logic                   dsp_idle_q, dsp_idle_d;
  logic                   dsp_valid_q, dsp_valid_d;
  logic [ID_WIDTH-1:0]    run_id_q, run_id_d;
  logic [PRI_WIDTH-1:0]   run_pri_q, run_pri_d;
  logic                   run_valid_q, run_valid_d;
  logic [COUNT_WIDTH-1:0] switch_count_q, switch_count_d;
  logic                   need_c;
  logic                   settled_c;

  // A switch is needed when the queue head no longer matches the running task.
  always_comb begin
    settled_c = (state_q == ST_IDLE) || (state_q == ST_RUN);
    need_c    = (top_valid && (!run_valid_q || (top_id != run_id_q) || (top_pri != run_pri_q)))
             || (!top_valid && run_valid_q);
  end

  always_comb begin
    state_d        = state_q;
    dsp_id_d       = dsp_id_q;
    dsp_pri_d      = dsp_pri_q;
    dsp_idle_d     = dsp_idle_q;
    dsp_valid_d    = dsp_valid_q;
    run_id_d       = run_id_q;
    run_pri_d      = run_pri_q;
    run_valid_d    = run_valid_q;
    switch_count_d = switch_count_q;
    if (cke) begin
      case (state_q)
        ST_IDLE, ST_RUN: begin
          if (need_c && !dis_dsp) begin
            dsp_id_d    = top_valid ? top_id : '0;
            dsp_pri_d   = top_valid ? top_pri : '0;
            dsp_idle_d  = !top_valid;
            dsp_valid_d = 1'b1;
            state_d     = ST_REQ;
          end
        end
        ST_REQ: begin
          // Request target is frozen until the CPU takes it.
          if (dsp_valid_q && dsp_ready) begin
            run_id_d       = dsp_id_q;
            run_pri_d      = dsp_pri_q;
            run_valid_d    = !dsp_idle_q;
            dsp_valid_d    = 1'b0;
            switch_count_d = switch_count_q + COUNT_WIDTH'(1);
            state_d        = dsp_idle_q ? ST_IDLE : ST_RUN;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      dsp_id_q       <= '0;
      dsp_pri_q      <= '0;
      dsp_idle_q     <= 1'b0;
      dsp_valid_q    <= 1'b0;
      run_id_q       <= '0;
      run_pri_q      <= '0;
      run_valid_q    <= 1'b0;
      switch_count_q <= '0;
    end else begin
      state_q        <= state_d;
      dsp_id_q       <= dsp_id_d;
      dsp_pri_q      <= dsp_pri_d;
      dsp_idle_q     <= dsp_idle_d;
      dsp_valid_q    <= dsp_valid_d;
      run_id_q       <= run_id_d;
      run_pri_q      <= run_pri_d;
      run_valid_q    <= run_valid_d;
      switch_count_q <= switch_count_d;
    end
  end

  assign dsp_id       = dsp_id_q;
  assign dsp_pri      = dsp_pri_q;
  assign dsp_idle     = dsp_idle_q;
  assign dsp_valid    = dsp_valid_q;
  assign run_id       = run_id_q;
  assign run_pri      = run_pri_q;
  assign run_valid    = run_valid_q;
  assign switch_count = switch_count_q;
  assign dsp_pend     = settled_c && need_c && dis_dsp;

endmodule

// File: tb/tb_jelly_rtos_dispatcher.sv
// Bench for jelly_rtos_dispatcher: expected switch requests are queued when the
// queue head is driven and popped when the DUT presents its request.
module tb_jelly_rtos_dispatcher;
  localparam int unsigned IW = 32;
  localparam int unsigned PW = 4;
  localparam int unsigned CW = 2;

  typedef struct packed {
    logic [IW-1:0] id;
    logic [PW-1:0] pri;
    logic          idle;
  } req_t;

  logic          clk = 1'b0;
  logic          reset, cke, top_valid, dis_dsp, dsp_ready;
  logic [IW-1:0] top_id;
  logic [PW-1:0] top_pri;
  logic [IW-1:0] dsp_id, run_id;
  logic [PW-1:0] dsp_pri, run_pri;
  logic          dsp_idle, dsp_valid, run_valid, dsp_pend;
  logic [CW-1:0] switch_count;

  int   total = 0;
  int   bad   = 0;
  req_t exp_q[$];
  req_t e;

  jelly_rtos_dispatcher #(.ID_WIDTH(IW), .PRI_WIDTH(PW), .COUNT_WIDTH(CW)) dut (
    .clk(clk), .reset(reset), .cke(cke),
    .top_id(top_id), .top_pri(top_pri), .top_valid(top_valid), .dis_dsp(dis_dsp),
    .dsp_id(dsp_id), .dsp_pri(dsp_pri), .dsp_idle(dsp_idle), .dsp_valid(dsp_valid),
    .dsp_ready(dsp_ready), .run_id(run_id), .run_pri(run_pri), .run_valid(run_valid),
    .dsp_pend(dsp_pend), .switch_count(switch_count)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled on the falling edge.
  task automatic step(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic set_top(input logic [IW-1:0] id, input logic [PW-1:0] pri, input logic v);
    top_id = id; top_pri = pri; top_valid = v;
  endtask

  function automatic req_t pop_exp();
    req_t r;
    r = '0;
    if (exp_q.size() != 0) r = exp_q.pop_front();
    else r.id = 32'hDEAD_BEEF;
    return r;
  endfunction

  task automatic test_reset();
    reset = 1'b1; cke = 1'b1; dis_dsp = 1'b0; dsp_ready = 1'b0;
    set_top(32'h0, 4'h0, 1'b0);
    step(5);
    reset = 1'b0;
    step(1);
    total++;
    if ({dsp_valid, run_valid, dsp_pend, switch_count} !== {3'b000, CW'(0)}) begin
      bad++;
      $display("FAIL reset valid/run/pend/count got %b%b%b %0d exp 0000", dsp_valid, run_valid, dsp_pend, switch_count);
    end
  endtask

  task automatic test_first_dispatch();
    set_top(32'h102, 4'd2, 1'b1); dsp_ready = 1'b1;
    exp_q.push_back('{32'h102, 4'd2, 1'b0});
    step(1);
    e = pop_exp();
    total++;
    if ({dsp_valid, dsp_id, dsp_pri, dsp_idle} !== {1'b1, e.id, e.pri, e.idle}) begin
      bad++;
      $display("FAIL first_req got v=%b id=%h pri=%0d idle=%b exp id=%h pri=%0d idle=%b", dsp_valid, dsp_id, dsp_pri, dsp_idle, e.id, e.pri, e.idle);
    end
    step(1);
    total++;
    if ({dsp_valid, run_valid, run_id, run_pri, switch_count} !== {1'b0, 1'b1, 32'h102, 4'd2, CW'(1)}) begin
      bad++;
      $display("FAIL first_run got v=%b rv=%b id=%h pri=%0d cnt=%0d exp 0 1 102 2 1", dsp_valid, run_valid, run_id, run_pri, switch_count);
    end
    step(2);
    total++;
    if (dsp_valid !== 1'b0) begin
      bad++; $display("FAIL first_quiet dsp_valid got %b exp 0", dsp_valid);
    end
  endtask

  task automatic test_hold_retarget();
    set_top(32'h100, 4'd0, 1'b1); dsp_ready = 1'b0;
    exp_q.push_back('{32'h100, 4'd0, 1'b0});
    step(1);
    set_top(32'h101, 4'd1, 1'b1);
    exp_q.push_back('{32'h101, 4'd1, 1'b0});
    e = pop_exp();
    for (int i = 0; i < 3; i++) begin
      total++;
      if ({dsp_valid, dsp_id, dsp_pri} !== {1'b1, e.id, e.pri}) begin
        bad++;
        $display("FAIL hold cyc%0d got v=%b id=%h pri=%0d exp id=%h pri=%0d", i, dsp_valid, dsp_id, dsp_pri, e.id, e.pri);
      end
      if (i < 2) step(1);
    end
    dsp_ready = 1'b1;
    step(1);
    total++;
    if ({dsp_valid, run_id, switch_count} !== {1'b0, 32'h100, CW'(2)}) begin
      bad++;
      $display("FAIL hold_gap got v=%b run=%h cnt=%0d exp 0 100 2", dsp_valid, run_id, switch_count);
    end
    step(1);
    e = pop_exp();
    total++;
    if ({dsp_valid, dsp_id, dsp_pri, dsp_idle} !== {1'b1, e.id, e.pri, e.idle}) begin
      bad++;
      $display("FAIL retarget got v=%b id=%h pri=%0d exp id=%h pri=%0d", dsp_valid, dsp_id, dsp_pri, e.id, e.pri);
    end
    step(1);
    total++;
    if ({run_id, run_pri, switch_count} !== {32'h101, 4'd1, CW'(3)}) begin
      bad++;
      $display("FAIL retarget_run got id=%h pri=%0d cnt=%0d exp 101 1 3", run_id, run_pri, switch_count);
    end
  endtask

  task automatic test_dispatch_lock();
    dis_dsp = 1'b1;
    set_top(32'h105, 4'd3, 1'b1);
    step(1);
    for (int i = 0; i < 2; i++) begin
      total++;
      if ({dsp_pend, dsp_valid} !== 2'b10) begin
        bad++; $display("FAIL lock cyc%0d pend/valid got %b%b exp 10", i, dsp_pend, dsp_valid);
      end
      step(1);
    end
    dis_dsp = 1'b0;
    exp_q.push_back('{32'h105, 4'd3, 1'b0});
    step(1);
    e = pop_exp();
    total++;
    if ({dsp_valid, dsp_pend, dsp_id, dsp_pri} !== {2'b10, e.id, e.pri}) begin
      bad++;
      $display("FAIL unlock got v=%b pend=%b id=%h pri=%0d exp 1 0 %h %0d", dsp_valid, dsp_pend, dsp_id, dsp_pri, e.id, e.pri);
    end
    dis_dsp = 1'b1;
    step(1);
    total++;
    if ({run_id, switch_count} !== {32'h105, CW'(0)}) begin
      bad++;
      $display("FAIL wrap got run=%h cnt=%0d exp 105 0", run_id, switch_count);
    end
    dis_dsp = 1'b0;
  endtask

  task automatic test_to_idle();
    set_top(32'h777, 4'd9, 1'b0);
    exp_q.push_back('{32'h0, 4'd0, 1'b1});
    step(1);
    e = pop_exp();
    total++;
    if ({dsp_valid, dsp_id, dsp_pri, dsp_idle} !== {1'b1, e.id, e.pri, e.idle}) begin
      bad++;
      $display("FAIL idle_req got v=%b id=%h pri=%0d idle=%b exp id=%h idle=%b", dsp_valid, dsp_id, dsp_pri, dsp_idle, e.id, e.idle);
    end
    step(1);
    total++;
    if ({run_valid, dsp_valid, switch_count} !== {2'b00, CW'(1)}) begin
      bad++;
      $display("FAIL idle_run got rv=%b v=%b cnt=%0d exp 0 0 1", run_valid, dsp_valid, switch_count);
    end
    step(2);
    total++;
    if ({dsp_valid, dsp_pend} !== 2'b00) begin
      bad++; $display("FAIL idle_quiet got v=%b pend=%b exp 00", dsp_valid, dsp_pend);
    end
  endtask

  task automatic test_cke_freeze();
    set_top(32'h200, 4'd5, 1'b1); dsp_ready = 1'b0;
    exp_q.push_back('{32'h200, 4'd5, 1'b0});
    step(1);
    cke = 1'b0; dsp_ready = 1'b1;
    set_top(32'h201, 4'd6, 1'b1);
    e = pop_exp();
    for (int i = 0; i < 3; i++) begin
      step(1);
      total++;
      if ({dsp_valid, dsp_id, dsp_pri, run_valid, switch_count} !== {1'b1, e.id, e.pri, 1'b0, CW'(1)}) begin
        bad++;
        $display("FAIL freeze cyc%0d got v=%b id=%h rv=%b cnt=%0d exp 1 %h 0 1", i, dsp_valid, dsp_id, run_valid, switch_count, e.id);
      end
    end
    set_top(32'h200, 4'd5, 1'b1);
    cke = 1'b1;
    step(1);
    total++;
    if ({dsp_valid, run_id, run_pri, switch_count} !== {1'b0, e.id, e.pri, CW'(2)}) begin
      bad++;
      $display("FAIL thaw got v=%b id=%h pri=%0d cnt=%0d exp 0 %h %0d 2", dsp_valid, run_id, run_pri, switch_count, e.id, e.pri);
    end
  endtask

  task automatic test_pri_change();
    set_top(32'h200, 4'd7, 1'b1);
    exp_q.push_back('{32'h200, 4'd7, 1'b0});
    step(1);
    e = pop_exp();
    total++;
    if ({dsp_valid, dsp_id, dsp_pri} !== {1'b1, e.id, e.pri}) begin
      bad++;
      $display("FAIL pri_change got v=%b id=%h pri=%0d exp 1 %h %0d", dsp_valid, dsp_id, dsp_pri, e.id, e.pri);
    end
    step(1);
    total++;
    if ({run_pri, switch_count} !== {4'd7, CW'(3)}) begin
      bad++; $display("FAIL pri_run got pri=%0d cnt=%0d exp 7 3", run_pri, switch_count);
    end
  endtask

  task automatic test_reset_mid_req();
    set_top(32'h300, 4'd1, 1'b1); dsp_ready = 1'b0;
    exp_q.push_back('{32'h300, 4'd1, 1'b0});
    step(1);
    total++;
    if (dsp_valid !== 1'b1) begin
      bad++; $display("FAIL rst_pre dsp_valid got %b exp 1", dsp_valid);
    end
    reset = 1'b1; dsp_ready = 1'b1;
    step(1);
    exp_q.delete();
    total++;
    if ({dsp_valid, dsp_id, dsp_pri, dsp_idle, run_valid, run_id, run_pri, switch_count} !== '0) begin
      bad++;
      $display("FAIL rst_mid got v=%b id=%h rv=%b run=%h cnt=%0d exp all 0", dsp_valid, dsp_id, run_valid, run_id, switch_count);
    end
    reset = 1'b0; set_top(32'h0, 4'd0, 1'b0);
    step(2);
    total++;
    if ({dsp_valid, switch_count} !== {1'b0, CW'(0)}) begin
      bad++; $display("FAIL rst_after got v=%b cnt=%0d exp 0 0", dsp_valid, switch_count);
    end
  endtask

  initial begin
    test_reset();
    test_first_dispatch();
    test_hold_retarget();
    test_dispatch_lock();
    test_to_idle();
    test_cke_freeze();
    test_pri_change();
    test_reset_mid_req();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
